// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by a synchronous transmit FIFO.
// Frames are start, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 868,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [DW-1:0] DIV_ZERO  = DW'(0);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                stop_q, stop_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                push_s, pop_s, nempty_s, bit_end_s;
  logic [DATA_W-1:0]   head_s;

  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    if (PARITY == 2) parity_of = ^w;
    else             parity_of = ~^w;
  endfunction

  assign in_ready   = (lvl_q != LVL_FULL);
  assign push_s     = in_valid && in_ready;
  assign nempty_s   = (lvl_q != LVL_ZERO);
  assign head_s     = mem_q[rd_q];
  assign bit_end_s  = (div_q == DIV_LAST);
  assign fifo_level = lvl_q;
  assign tx         = tx_q;
  assign busy       = busy_q;

  // Storage array carries no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_q] <= in_data;
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push_s) wr_d = wr_q + PTR_ONE;
    else        wr_d = wr_q;
    if (pop_s)  rd_d = rd_q + PTR_ONE;
    else        rd_d = rd_q;
    case ({push_s, pop_s})
      2'b10:   lvl_d = lvl_q + LVL_ONE;
      2'b01:   lvl_d = lvl_q - LVL_ONE;
      default: lvl_d = lvl_q;
    endcase
  end

  // Frame sequencer: bit timing, shifting and the line value for the next cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        pop_s = nempty_s;
      end
      ST_START: begin
        if (bit_end_s) begin
          div_d   = DIV_ZERO;
          bit_d   = BIT_ZERO;
          tx_d    = sh_q[0];
          state_d = ST_DATA;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          div_d = DIV_ZERO;
          if (bit_q == BIT_LAST) begin
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + BIT_ONE;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          div_d   = DIV_ZERO;
          state_d = ST_STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          div_d = DIV_ZERO;
          if (stop_q == STOP_LAST) begin
            if (nempty_s) begin
              pop_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = DIV_ZERO;
        tx_d    = 1'b1;
      end
    endcase
    // A pop always launches a start bit on the same edge, from IDLE or straight out of STOP.
    if (pop_s) begin
      sh_d    = head_s;
      par_d   = parity_of(head_s);
      tx_d    = 1'b0;
      div_d   = DIV_ZERO;
      state_d = ST_START;
    end else begin
      sh_d = sh_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Control and line registers; reset idles the line immediately and flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_ZERO;
      bit_q   <= BIT_ZERO;
      stop_q  <= 1'b0;
      sh_q    <= {DATA_W{1'b0}};
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      wr_q    <= PTR_ZERO;
      rd_q    <= PTR_ZERO;
      lvl_q   <= LVL_ZERO;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations, each frame checked bit by bit on tx.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_s [4];
  logic [7:0] data_s  [4];
  logic       ready_s [4];
  logic [2:0] lvl_s   [4];
  logic       tx_s    [4];
  logic       busy_s  [4];

  int         checks = 0;
  int         errors = 0;
  int         cur    = 0;
  logic       xfer   = 1'b0;
  logic [7:0] pend [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(valid_s[0]), .in_data(data_s[0]), .in_ready(ready_s[0]),
    .fifo_level(lvl_s[0]), .tx(tx_s[0]), .busy(busy_s[0]));
  uart_tx_fifo #(.DATA_W(8), .CLK_DIV(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(valid_s[1]), .in_data(data_s[1]), .in_ready(ready_s[1]),
    .fifo_level(lvl_s[1]), .tx(tx_s[1]), .busy(busy_s[1]));
  uart_tx_fifo #(.DATA_W(8), .CLK_DIV(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(valid_s[2]), .in_data(data_s[2]), .in_ready(ready_s[2]),
    .fifo_level(lvl_s[2]), .tx(tx_s[2]), .busy(busy_s[2]));
  uart_tx_fifo #(.DATA_W(7), .CLK_DIV(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rst(rst), .in_valid(valid_s[3]), .in_data(data_s[3][6:0]), .in_ready(ready_s[3]),
    .fifo_level(lvl_s[3]), .tx(tx_s[3]), .busy(busy_s[3]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and let the producer offer the head of pend.
  task automatic tick();
    @(negedge clk);
    if (xfer) pend.delete(0);
    if (pend.size() != 0) begin
      valid_s[cur] = 1'b1;
      data_s[cur]  = pend[0];
    end else begin
      valid_s[cur] = 1'b0;
    end
    xfer = valid_s[cur] && ready_s[cur];
  endtask

  // Check nbits*4 cycles of tx against bits (bit 0 = start bit); optional level probe and late push.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                             input int lvl_c, input logic [2:0] lvl_exp,
                             input int act_c, input logic [7:0] act_d);
    for (int c = 0; c < nbits * 4; c++) begin
      if (c == act_c) pend.push_back(act_d);
      tick();
      chk($sformatf("%s tx c%0d", tag, c), 16'(tx_s[cur]), 16'(bits[c / 4]));
      chk($sformatf("%s busy c%0d", tag, c), 16'(busy_s[cur]), 16'h0001);
      if (c == lvl_c) chk($sformatf("%s level c%0d", tag, c), 16'(lvl_s[cur]), 16'(lvl_exp));
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s tx idle %0d", tag, i), 16'(tx_s[cur]), 16'h0001);
      chk($sformatf("%s busy idle %0d", tag, i), 16'(busy_s[cur]), 16'h0000);
    end
  endtask

  // Queue words, offer the first at edge N and the frame's start bit appears at edge N+1.
  task automatic start_words(input string tag);
    tick();
    chk({tag, " ready pre"}, 16'(ready_s[cur]), 16'h0001);
    chk({tag, " level pre"}, 16'(lvl_s[cur]), 16'h0000);
    tick();
    chk({tag, " level N"}, 16'(lvl_s[cur]), 16'h0001);
    chk({tag, " tx N"}, 16'(tx_s[cur]), 16'h0001);
    chk({tag, " busy N"}, 16'(busy_s[cur]), 16'h0000);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      valid_s[k] = 1'b0;
      data_s[k]  = 8'h00;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst tx %0d", k), 16'(tx_s[k]), 16'h0001);
      chk($sformatf("rst busy %0d", k), 16'(busy_s[k]), 16'h0000);
      chk($sformatf("rst ready %0d", k), 16'(ready_s[k]), 16'h0001);
      chk($sformatf("rst level %0d", k), 16'(lvl_s[k]), 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;

    // 8N1 single word 0x55: 40-cycle frame, busy exactly for the frame.
    cur = 0;
    pend.push_back(8'h55);
    start_words("n81");
    check_frame("n81 55", {1'b1, 8'h55, 1'b0}, 10, 0, 3'd0, -1, 8'h00);
    check_idle("n81", 4);

    // Even parity on 0x07 gives parity bit 1; 44-cycle frame.
    cur = 1;
    pend.push_back(8'h07);
    start_words("even");
    check_frame("even 07", {1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 3'd0, -1, 8'h00);
    check_idle("even", 4);

    // Odd parity on 0x07 gives parity bit 0.
    cur = 2;
    pend.push_back(8'h07);
    start_words("odd");
    check_frame("odd 07", {1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 3'd0, -1, 8'h00);
    check_idle("odd", 4);

    // 7 data bits, 2 stop bits: second start exactly 40 cycles after the first.
    cur = 3;
    pend.push_back(8'h7F);
    pend.push_back(8'h2A);
    start_words("7n2");
    check_frame("7n2 7F", {2'b11, 7'h7F, 1'b0}, 10, 0, 3'd1, -1, 8'h00);
    check_frame("7n2 2A", {2'b11, 7'h2A, 1'b0}, 10, 0, 3'd0, -1, 8'h00);
    check_idle("7n2", 4);

    // Six words with valid held: FIFO fills, stalls, then frames run back-to-back in order.
    cur = 0;
    for (int w = 1; w <= 6; w++) pend.push_back(8'(w));
    start_words("b2b");
    check_frame("b2b 01", {1'b1, 8'h01, 1'b0}, 10, 3, 3'd4, -1, 8'h00);
    chk("b2b full ready", 16'(ready_s[0]), 16'h0000);
    chk("b2b full level", 16'(lvl_s[0]), 16'h0004);
    check_frame("b2b 02", {1'b1, 8'h02, 1'b0}, 10, 0, 3'd3, -1, 8'h00);
    check_frame("b2b 03", {1'b1, 8'h03, 1'b0}, 10, 0, 3'd3, -1, 8'h00);
    check_frame("b2b 04", {1'b1, 8'h04, 1'b0}, 10, 0, 3'd2, -1, 8'h00);
    check_frame("b2b 05", {1'b1, 8'h05, 1'b0}, 10, 0, 3'd1, -1, 8'h00);
    check_frame("b2b 06", {1'b1, 8'h06, 1'b0}, 10, 0, 3'd0, -1, 8'h00);
    check_idle("b2b", 12);

    // Push lands on the same edge as the STOP->START pop with one word buffered.
    pend.push_back(8'hA5);
    pend.push_back(8'h3C);
    start_words("same");
    check_frame("same A5", {1'b1, 8'hA5, 1'b0}, 10, 0, 3'd1, 39, 8'hC3);
    check_frame("same 3C", {1'b1, 8'h3C, 1'b0}, 10, 0, 3'd1, -1, 8'h00);
    check_frame("same C3", {1'b1, 8'hC3, 1'b0}, 10, 0, 3'd0, -1, 8'h00);
    check_idle("same", 4);

    // Reset during the first frame's data bits: line idles without a clock edge.
    pend.push_back(8'h11);
    pend.push_back(8'h22);
    pend.push_back(8'h33);
    start_words("arst");
    for (int c = 0; c < 10; c++) tick();
    chk("arst tx before", 16'(tx_s[0]), 16'h0000);
    chk("arst level before", 16'(lvl_s[0]), 16'h0002);
    #2 rst = 1'b1;
    #1;
    chk("arst tx", 16'(tx_s[0]), 16'h0001);
    chk("arst level", 16'(lvl_s[0]), 16'h0000);
    chk("arst busy", 16'(busy_s[0]), 16'h0000);
    chk("arst ready", 16'(ready_s[0]), 16'h0001);
    pend.delete();
    valid_s[0] = 1'b0;
    xfer = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle("post rst", 60);
    chk("post rst level", 16'(lvl_s[0]), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
